// File: rtl/sample_window_if.sv
// Bundles the sample-window stimulus and observation signals; master drives samples, slave is the window.
// min_smpl/max_smpl exist only when SAMPLE_WINDOW_MINMAX_EN is defined.
interface sample_window_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 14
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = DATA_WIDTH + CNT_W;

  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_smpl;
  logic                        clr;
  logic                        freeze;
  logic [DEPTH*DATA_WIDTH-1:0] out_smpls;
  logic [PTR_W-1:0]            wr_ptr;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic [SUM_W-1:0]            sum;
  logic                        overrun;

`ifdef SAMPLE_WINDOW_MINMAX_EN
  logic [DATA_WIDTH-1:0]       min_smpl;
  logic [DATA_WIDTH-1:0]       max_smpl;

  modport master (
    output in_valid, in_smpl, clr, freeze,
    input  out_smpls, wr_ptr, count, full, sum, overrun, min_smpl, max_smpl
  );

  modport slave (
    input  in_valid, in_smpl, clr, freeze,
    output out_smpls, wr_ptr, count, full, sum, overrun, min_smpl, max_smpl
  );
`else
  modport master (
    output in_valid, in_smpl, clr, freeze,
    input  out_smpls, wr_ptr, count, full, sum, overrun
  );

  modport slave (
    input  in_valid, in_smpl, clr, freeze,
    output out_smpls, wr_ptr, count, full, sum, overrun
  );
`endif
endinterface

// File: rtl/sample_window.sv
// Circular window of the last DEPTH samples with running sum; writes visible 1 cycle later, min/max (SAMPLE_WINDOW_MINMAX_EN) 2 cycles.
// No backpressure: every offered sample is stored unless clr wins or freeze drops it (dropped samples set sticky overrun).
module sample_window #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  sample_window_if.slave  win
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = DATA_WIDTH + CNT_W;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [SUM_W-1:0]      sum_q;
  logic                  overrun_q;

  logic                  full;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [SUM_W-1:0]      sum_nxt;
  logic [DATA_WIDTH-1:0] evict_smpl;

  assign full  = (count_q == FULL_CNT);
  assign wr_en = win.in_valid & ~win.freeze & ~win.clr;

  always_comb begin
    wr_ptr_nxt = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    count_nxt  = full ? count_q : count_q + CNT_W'(1);
    // Once full, the slot being overwritten leaves the window, so its value leaves the sum.
    evict_smpl = full ? slot_q[wr_ptr_q] : '0;
    sum_nxt    = sum_q + SUM_W'(win.in_smpl) - SUM_W'(evict_smpl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else if (win.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else if (win.freeze) begin
      if (win.in_valid) begin
        overrun_q <= 1'b1;
      end
    end else if (wr_en) begin
      slot_q[wr_ptr_q] <= win.in_smpl;
      wr_ptr_q         <= wr_ptr_nxt;
      count_q          <= count_nxt;
      sum_q            <= sum_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign win.out_smpls[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
  end

  assign win.wr_ptr  = wr_ptr_q;
  assign win.count   = count_q;
  assign win.full    = full;
  assign win.sum     = sum_q;
  assign win.overrun = overrun_q;

`ifdef SAMPLE_WINDOW_MINMAX_EN
  logic [DATA_WIDTH-1:0] min_comb;
  logic [DATA_WIDTH-1:0] max_comb;
  logic [DATA_WIDTH-1:0] min_q;
  logic [DATA_WIDTH-1:0] max_q;

  // Slots fill from 0 upward after clear/reset, so indices below count are exactly the valid ones.
  always_comb begin
    min_comb = '1;
    max_comb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (slot_q[i] < min_comb) min_comb = slot_q[i];
        if (slot_q[i] > max_comb) max_comb = slot_q[i];
      end
    end
    if (count_q == '0) begin
      min_comb = '0;
    end
  end

  // clr zeroes these in the same edge as count so they never show stale extremes of an empty window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else if (win.clr) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_comb;
      max_q <= max_comb;
    end
  end

  assign win.min_smpl = min_q;
  assign win.max_smpl = max_q;
`endif
endmodule

// File: tb/tb_sample_window.sv
// Directed, table-driven bench for sample_window at DATA_WIDTH=12, DEPTH=4.
module tb_sample_window;
  localparam int DW = 12;
  localparam int DP = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sample_window_if #(.DATA_WIDTH(DW), .DEPTH(DP)) win ();

  sample_window #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (win.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    logic [11:0] smpl;
    bit          clr;
    bit          frz;
    logic [47:0] e_smpls;
    logic [1:0]  e_ptr;
    logic [2:0]  e_cnt;
    bit          e_full;
    logic [14:0] e_sum;
    bit          e_ovr;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic logic [47:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {12'(s3), 12'(s2), 12'(s1), 12'(s0)};
  endfunction

  function automatic vec_t mk(input bit v, input int s, input bit c, input bit f,
                              input logic [47:0] sm, input int p, input int n,
                              input bit fu, input int su, input bit ov);
    vec_t r;
    r.vld = v; r.smpl = 12'(s); r.clr = c; r.frz = f;
    r.e_smpls = sm; r.e_ptr = 2'(p); r.e_cnt = 3'(n);
    r.e_full = fu; r.e_sum = 15'(su); r.e_ovr = ov;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int s, input bit c, input bit f);
    win.in_valid = v;
    win.in_smpl  = 12'(s);
    win.clr      = c;
    win.freeze   = f;
  endtask

  task automatic chk_state(input string tag, input logic [47:0] sm, input int p, input int n,
                           input bit fu, input int su, input bit ov);
    chk({tag, "_smpls"},   64'(win.out_smpls), 64'(sm));
    chk({tag, "_ptr"},     64'(win.wr_ptr),    64'(p));
    chk({tag, "_cnt"},     64'(win.count),     64'(n));
    chk({tag, "_full"},    64'(win.full),      64'(fu));
    chk({tag, "_sum"},     64'(win.sum),       64'(su));
    chk({tag, "_overrun"}, 64'(win.overrun),   64'(ov));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            vld smpl clr frz  slots                  ptr cnt full sum   ovr
    tbl[0]  = mk(1, 10,   0, 0, pk(10, 0, 0, 0),        1, 1, 0, 10,    0);
    tbl[1]  = mk(1, 20,   0, 0, pk(10, 20, 0, 0),       2, 2, 0, 30,    0);
    tbl[2]  = mk(1, 30,   0, 0, pk(10, 20, 30, 0),      3, 3, 0, 60,    0);
    tbl[3]  = mk(0, 999,  0, 0, pk(10, 20, 30, 0),      3, 3, 0, 60,    0);
    tbl[4]  = mk(1, 40,   0, 0, pk(10, 20, 30, 40),     0, 4, 1, 100,   0);
    tbl[5]  = mk(1, 50,   0, 0, pk(50, 20, 30, 40),     1, 4, 1, 140,   0);
    tbl[6]  = mk(1, 99,   0, 1, pk(50, 20, 30, 40),     1, 4, 1, 140,   1);
    tbl[7]  = mk(1, 77,   0, 1, pk(50, 20, 30, 40),     1, 4, 1, 140,   1);
    tbl[8]  = mk(0, 0,    0, 0, pk(50, 20, 30, 40),     1, 4, 1, 140,   1);
    tbl[9]  = mk(1, 60,   0, 0, pk(50, 60, 30, 40),     2, 4, 1, 180,   1);
    tbl[10] = mk(1, 5,    1, 0, pk(0, 0, 0, 0),         0, 0, 0, 0,     0);
    tbl[11] = mk(1, 8,    1, 1, pk(0, 0, 0, 0),         0, 0, 0, 0,     0);
    tbl[12] = mk(1, 1,    0, 0, pk(1, 0, 0, 0),         1, 1, 0, 1,     0);
    tbl[13] = mk(1, 4095, 0, 0, pk(1, 4095, 0, 0),      2, 2, 0, 4096,  0);
    tbl[14] = mk(1, 4095, 0, 0, pk(1, 4095, 4095, 0),   3, 3, 0, 8191,  0);
    tbl[15] = mk(1, 4095, 0, 0, pk(1, 4095, 4095, 4095), 0, 4, 1, 12286, 0);
    tbl[16] = mk(1, 4095, 0, 0, pk(4095, 4095, 4095, 4095), 1, 4, 1, 16380, 0);
    tbl[17] = mk(0, 3,    0, 1, pk(4095, 4095, 4095, 4095), 1, 4, 1, 16380, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    step();
    step();
    chk_state("reset", '0, 0, 0, 0, 0, 0);
`ifdef SAMPLE_WINDOW_MINMAX_EN
    chk("reset_min", 64'(win.min_smpl), 64'(0));
    chk("reset_max", 64'(win.max_smpl), 64'(0));
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].vld, int'(tbl[i].smpl), tbl[i].clr, tbl[i].frz);
      step();
      chk_state($sformatf("v%0d", i), tbl[i].e_smpls, int'(tbl[i].e_ptr), int'(tbl[i].e_cnt),
                tbl[i].e_full, int'(tbl[i].e_sum), tbl[i].e_ovr);
    end

    // Asynchronous reset in the middle of a cycle, with overrun set beforehand.
    drive(0, 0, 1, 0); step();
    drive(1, 11, 0, 0); step();
    drive(1, 22, 0, 0); step();
    drive(1, 33, 0, 0); step();
    drive(1, 44, 0, 1); step();
    chk("pre_rst_overrun", 64'(win.overrun), 64'(1));
    chk("pre_rst_cnt",     64'(win.count),   64'(3));
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", '0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    step();
    drive(1, 7, 0, 0); step();
    chk_state("post_rst", pk(7, 0, 0, 0), 1, 1, 0, 7, 0);

`ifdef SAMPLE_WINDOW_MINMAX_EN
    drive(0, 0, 1, 0); step();
    chk("mm_clr_min", 64'(win.min_smpl), 64'(0));
    chk("mm_clr_max", 64'(win.max_smpl), 64'(0));
    drive(1, 4095, 0, 0); step();
    // Extremes lag the slots by a cycle, so the empty window still shows here.
    chk("mm_lag_min", 64'(win.min_smpl), 64'(0));
    chk("mm_lag_max", 64'(win.max_smpl), 64'(0));
    drive(1, 0, 0, 0); step();
    drive(1, 100, 0, 0); step();
    drive(0, 0, 0, 0); step();
    chk("mm_a_min", 64'(win.min_smpl), 64'(0));
    chk("mm_a_max", 64'(win.max_smpl), 64'(4095));
    drive(1, 5, 0, 0); step();
    drive(1, 6, 0, 0); step();
    drive(0, 0, 0, 0); step();
    // Window is now {6, 0, 100, 5}: 4095 evicted, the 0 sample is still present.
    chk("mm_b_max", 64'(win.max_smpl), 64'(100));
    chk("mm_b_min", 64'(win.min_smpl), 64'(0));
`endif

    drive(0, 0, 0, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
